// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch port (read only) and the data port (read/write, byte flag). One
// access at a time: IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ack pulse).
// Data requests win over fetch requests in IDLE.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
// data grants made while a fetch was waiting, the next grant goes to fetch.

module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   // memory side
   output logic        mem_en,
   output logic        mem_we,
   output logic        mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   // status
   output logic        busy
);

   // Both counters are 4 bits wide, so both parameters are limited to 1..15.
   if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
      $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
   end

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   state_t      state_q,   state_d;
   logic [3:0]  cnt_q,     cnt_d;
   owner_t      owner_q,   owner_d;
   logic [31:0] addr_q,    addr_d;
   logic        we_q,      we_d;
   logic        be_q,      be_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        i_ack_q,   i_ack_d;
   logic        d_ack_q,   d_ack_d;

   logic        grant_i;
   logic        grant_d;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;
   logic       force_i;

   // Grant selection: data first, unless fetch has waited out STARVE_MAX data grants.
   always_comb begin
      force_i = i_req && (starve_q == STARVE_LIM);
      grant_i = i_req && (!d_req || force_i);
      grant_d = d_req && !grant_i;
   end

   // Starvation counter: counts data grants that overtook a waiting fetch.
   always_comb begin
      starve_d = starve_q;
      if (state_q == ST_IDLE) begin
         if (grant_i) begin
            starve_d = '0;
         end else if (grant_d) begin
            // Cannot pass STARVE_LIM: at the limit with i_req high, fetch is forced.
            starve_d = i_req ? starve_q + 4'd1 : '0;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   // Grant selection: strict data-over-fetch priority.
   always_comb begin
      grant_d = d_req;
      grant_i = i_req && !d_req;
   end
`endif

   // Next-state and datapath logic for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch can leave one
      // unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               owner_d = OWN_D;
               addr_d  = d_addr;
               we_d    = d_we;
               be_d    = d_be;
               wdata_d = d_wdata;
               cnt_d   = LAT_M1;
               state_d = ST_ACCESS;
            end else if (grant_i) begin
               owner_d = OWN_I;
               addr_d  = i_addr;
               we_d    = 1'b0;
               be_d    = 1'b0;
               wdata_d = '0;
               cnt_d   = LAT_M1;
               state_d = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Last latency cycle: read data is valid now; the ack register
               // is loaded so the pulse lines up with the DONE cycle.
               state_d = ST_DONE;
               if (owner_q == OWN_D) begin
                  d_ack_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = mem_rdata;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         owner_q   <= OWN_I;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
      end
   end

   // Memory side is driven from the latched request copy, so it stays stable
   // for the whole access even if the requester changes its fields.
   assign mem_en    = (state_q == ST_ACCESS);
   assign mem_we    = mem_en && we_q;
   assign mem_be    = mem_en && be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign i_rdata   = i_rdata_q;
   assign i_ack     = i_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed timing scenarios, randomized
// two-requester traffic checked by a scoreboard against a reference memory,
// and a MEM_LAT=1 throughput sweep on a second instance.
// Builds with or without ARB_STARVE_GUARD_EN; the starvation expectation
// follows the macro.

module tb_mem_port_arbiter;

   localparam int unsigned MEM_LAT    = 2;
   localparam int unsigned STARVE_MAX = 4;
   localparam int          ACK_LAT    = int'(MEM_LAT) + 1;  // request cycle -> ack cycle
   localparam int          PERIOD     = int'(MEM_LAT) + 2;  // ack-to-ack when saturated

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, d_be;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_en, mem_we, mem_be, busy;

   // second instance, MEM_LAT = 1
   logic        s_i_req, s_d_req;
   logic [31:0] s_i_addr, s_d_addr;
   logic [31:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
   logic        s_i_ack, s_d_ack, s_mem_en, s_mem_we, s_mem_be, s_busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .i_req(s_i_req), .i_addr(s_i_addr), .i_rdata(s_i_rdata), .i_ack(s_i_ack),
      .d_req(s_d_req), .d_we(1'b0), .d_be(1'b0), .d_addr(s_d_addr), .d_wdata(32'h0),
      .d_rdata(s_d_rdata), .d_ack(s_d_ack),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_be(s_mem_be), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .busy(s_busy)
   );

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, {31'h0, act}, {31'h0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- memory device models ----------------
   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] rom_val(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   logic [31:0] phys_mem [0:4095];  // what the memory device holds
   logic [31:0] ref_mem  [0:4095];  // what the reference model believes
   int          acc_k = 0;          // completed access cycles seen so far
   logic [31:0] acc_addr, acc_wdata;
   logic [1:0]  acc_ctl;

   // Read data only appears in the last latency cycle; garbage otherwise.
   always_comb begin
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_en && acc_k == int'(MEM_LAT)) begin
         mem_rdata = mem_be ? {24'h0, phys_mem[mem_addr[13:2]][7:0]}
                            : phys_mem[mem_addr[13:2]];
      end
   end

   assign s_mem_rdata = s_mem_en ? rom_val(s_mem_addr) : 32'hDEAD_BEEF;

   // Memory device: latency tracking, port-stability checks, write commit.
   initial forever begin
      @(negedge clk);
      if (reset || !mem_en) begin
         acc_k = 0;
      end else begin
         if (acc_k == 0) begin
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
            acc_ctl   = {mem_we, mem_be};
         end else begin
            check("mem_addr_stable", mem_addr, acc_addr);
            check("mem_wdata_stable", mem_wdata, acc_wdata);
            check("mem_ctl_stable", {30'h0, mem_we, mem_be}, {30'h0, acc_ctl});
         end
         if (mem_we && acc_k == int'(MEM_LAT) - 1) begin
            if (mem_be) phys_mem[mem_addr[13:2]][7:0] = mem_wdata[7:0];
            else        phys_mem[mem_addr[13:2]]      = mem_wdata;
         end
         acc_k = acc_k + 1;
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] i_exp_q[$];
   logic [31:0] d_exp_q[$];
   logic [31:0] d_last = 32'h0;  // value d_rdata should be holding

   task automatic push_i(input logic [31:0] a);
      i_exp_q.push_back(ref_mem[a[13:2]]);
   endtask

   task automatic push_d(input logic we, input logic be, input logic [31:0] a,
                         input logic [31:0] wd);
      if (we) begin
         if (be) ref_mem[a[13:2]][7:0] = wd[7:0];
         else    ref_mem[a[13:2]]      = wd;
      end else begin
         d_last = be ? {24'h0, ref_mem[a[13:2]][7:0]} : ref_mem[a[13:2]];
      end
      d_exp_q.push_back(d_last);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      phys_mem[a[13:2]] = v;
      ref_mem[a[13:2]]  = v;
   endtask

   // Monitor: compares every ack against the oldest expectation for that port.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (i_ack || d_ack) check_bit("ack_exclusive", i_ack && d_ack, 1'b0);
         if (i_ack) begin
            check_bit("i_ack_expected", i_exp_q.size() != 0, 1'b1);
            if (i_exp_q.size() != 0) check("i_rdata", i_rdata, i_exp_q.pop_front());
         end
         if (d_ack) begin
            check_bit("d_ack_expected", d_exp_q.size() != 0, 1'b1);
            if (d_exp_q.size() != 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
         end
      end
   end

   task automatic wait_ack(input bit is_d, input int budget, output int at);
      at = -1;
      for (int n = 0; n < budget; n++) begin
         step();
         if ((is_d ? d_ack : i_ack) === 1'b1) begin
            at = cyc;
            return;
         end
      end
   endtask

   function automatic bit starve_owner_is_d(input int k);
`ifdef ARB_STARVE_GUARD_EN
      return (k % (int'(STARVE_MAX) + 1)) != int'(STARVE_MAX);
`else
      return (k >= 0);
`endif
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0, at, d_at, i_at, acks, prev;
      bit cur_d, got;
      logic [31:0] cur_addr;

      for (int a = 0; a < 4096; a++) begin
         phys_mem[a] = init_val(32'(a * 4));
         ref_mem[a]  = init_val(32'(a * 4));
      end
      preload(32'h10, 32'hE3A0_0001);
      preload(32'h20, 32'h0000_00AA);

      reset = 1'b1;
      {i_req, d_req, d_we, d_be} = '0;
      {i_addr, d_addr, d_wdata} = '0;
      {s_i_req, s_d_req} = '0;
      {s_i_addr, s_d_addr} = '0;
      repeat (3) step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst_acks_en", {28'h0, i_ack, d_ack, mem_en, busy}, 32'h0);
      check("rst_mem_ctl", {30'h0, mem_we, mem_be}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);

      // Fetch read of 0x10
      i_req = 1'b1; i_addr = 32'h10; push_i(32'h10);
      step();
      check_bit("t1_c1_mem_en", mem_en, 1'b1);
      check("t1_c1_mem_addr", mem_addr, 32'h10);
      check_bit("t1_c1_mem_we", mem_we, 1'b0);
      check_bit("t1_c1_busy", busy, 1'b1);
      step();
      check_bit("t1_c2_mem_en", mem_en, 1'b1);
      check_bit("t1_c2_i_ack", i_ack, 1'b0);
      step();
      check_bit("t1_c3_i_ack", i_ack, 1'b1);
      check_bit("t1_c3_mem_en", mem_en, 1'b0);
      i_req = 1'b0;
      step();
      check_bit("t1_c4_busy", busy, 1'b0);
      check_bit("t1_c4_i_ack", i_ack, 1'b0);
      check("t1_c4_i_rdata_hold", i_rdata, 32'hE3A0_0001);

      // Collision: D read of 0x20 wins, I of 0x30 follows
      i_req = 1'b1; i_addr = 32'h30; push_i(32'h30);
      d_req = 1'b1; d_we = 1'b0; d_be = 1'b0; d_addr = 32'h20; push_d(1'b0, 1'b0, 32'h20, 32'h0);
      t0 = cyc; d_at = -1; i_at = -1;
      for (int n = 0; n < 30 && (d_at < 0 || i_at < 0); n++) begin
         step();
         if (d_ack) begin d_at = cyc - t0; d_req = 1'b0; end
         if (i_ack) begin i_at = cyc - t0; i_req = 1'b0; end
      end
      check("t3_d_ack_cycle", d_at, ACK_LAT);
      check("t3_i_ack_cycle", i_at, ACK_LAT + PERIOD);
      step();

      // Byte write of 0x7 to 0x64, then read it back
      d_req = 1'b1; d_we = 1'b1; d_be = 1'b1; d_addr = 32'h64; d_wdata = 32'h7;
      push_d(1'b1, 1'b1, 32'h64, 32'h7);
      t0 = cyc;
      for (int n = 0; n < int'(MEM_LAT); n++) begin
         step();
         check("t2_mem_we_be", {30'h0, mem_we, mem_be}, 32'h3);
         check("t2_mem_wdata", mem_wdata, 32'h7);
      end
      wait_ack(1'b1, 10, at);
      check("t2_d_ack_cycle", at - t0, ACK_LAT);
      d_we = 1'b0; d_wdata = 32'hFFFF_FFFF;  // fields change; access must not care
      push_d(1'b0, 1'b1, 32'h64, 32'h0);
      t0 = cyc;
      wait_ack(1'b1, 20, at);
      check("t2_readback_cycle", at - t0, PERIOD);
      d_req = 1'b0;
      step();

      // Request dropped after one cycle still completes
      i_req = 1'b1; i_addr = 32'h48; push_i(32'h48);
      t0 = cyc;
      step();
      i_req = 1'b0;
      wait_ack(1'b0, 10, at);
      check("t6_dropped_ack_cycle", at - t0, ACK_LAT);
      step();

      // Reset in the second ACCESS cycle
      d_req = 1'b1; d_we = 1'b0; d_be = 1'b0; d_addr = 32'h100;
      step();
      step();
      check_bit("t4_in_access", mem_en, 1'b1);
      reset = 1'b1;
      #1;
      check("t4_rst_outputs", {28'h0, mem_en, busy, i_ack, d_ack}, 32'h0);
      check("t4_rst_d_rdata", d_rdata, 32'h0);
      d_last = 32'h0;
      d_req = 1'b0;
      i_exp_q.delete(); d_exp_q.delete();
      step();
      reset = 1'b0;
      acks = 0;
      for (int n = 0; n < 6; n++) begin
         step();
         if (i_ack || d_ack) acks++;
      end
      check("t4_no_ack_after_reset", acks, 0);
      i_req = 1'b1; i_addr = 32'h44; push_i(32'h44);
      t0 = cyc;
      wait_ack(1'b0, 10, at);
      check("t4_new_req_cycle", at - t0, ACK_LAT);
      i_req = 1'b0;
      step();

      // Both requests held: starvation behaviour
      for (int k = 0; k < 10; k++) begin
         if (starve_owner_is_d(k)) push_d(1'b0, 1'b0, 32'h40, 32'h0);
         else                      push_i(32'h50);
      end
      i_req = 1'b1; i_addr = 32'h50;
      d_req = 1'b1; d_we = 1'b0; d_be = 1'b0; d_addr = 32'h40;
      prev = cyc;
      for (int k = 0; k < 10; k++) begin
         got = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = i_ack || d_ack;
         end
         check_bit("t5_ack_seen", got, 1'b1);
         if (!got) break;
         check_bit("t5_owner_is_d", d_ack, starve_owner_is_d(k));
         check("t5_ack_gap", cyc - prev, (k == 0) ? ACK_LAT : PERIOD);
         prev = cyc;
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) step();
      i_exp_q.delete(); d_exp_q.delete();

      // Random two-requester traffic
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               int a;
               repeat ($urandom_range(0, 4)) step();
               i_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
               i_req = 1'b1; push_i(i_addr);
               wait_ack(1'b0, 400, a);
               check_bit("rnd_i_ack_in_time", a >= 0, 1'b1);
               i_req = 1'b0;
            end
         end
         begin
            for (int n = 0; n < 40; n++) begin
               int a;
               repeat ($urandom_range(0, 4)) step();
               d_we = 1'($urandom); d_be = 1'($urandom);
               d_addr = 32'h100 + 32'($urandom_range(0, 7) * 4);
               d_wdata = $urandom;
               d_req = 1'b1; push_d(d_we, d_be, d_addr, d_wdata);
               wait_ack(1'b1, 400, a);
               check_bit("rnd_d_ack_in_time", a >= 0, 1'b1);
               d_req = 1'b0;
            end
         end
      join
      repeat (4) step();
      check("rnd_i_queue_drained", i_exp_q.size(), 0);
      check("rnd_d_queue_drained", d_exp_q.size(), 0);

      // MEM_LAT=1 sweep: alternating I/D reads, one ack every 3 cycles
      cur_d = 1'b0; cur_addr = 32'h200;
      s_i_addr = cur_addr; s_i_req = 1'b1;
      prev = cyc;
      for (int k = 0; k < 12; k++) begin
         got = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = s_i_ack || s_d_ack;
         end
         check_bit("sweep_ack_seen", got, 1'b1);
         if (!got) break;
         check_bit("sweep_owner_is_d", s_d_ack, cur_d);
         check("sweep_rdata", cur_d ? s_d_rdata : s_i_rdata, rom_val(cur_addr));
         check("sweep_gap", cyc - prev, (k == 0) ? 2 : 3);
         prev = cyc;
         cur_addr = 32'h300 + 32'(k * 8);
         cur_d = !cur_d;
         if (cur_d) begin s_i_req = 1'b0; s_d_addr = cur_addr; s_d_req = 1'b1; end
         else       begin s_d_req = 1'b0; s_i_addr = cur_addr; s_i_req = 1'b1; end
      end
      s_i_req = 1'b0; s_d_req = 1'b0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch port (read only) and the data port (read/write, byte-access flag).
- Sits between the processor core's fetch/memory stages and the memory. The arbiter serialises accesses and returns a one-cycle ack per completed access.
- The core stalls a stage while that stage's req is high and its ack has not yet returned.

Parameters:
- MEM_LAT, 2, memory read/write latency in cycles; legal range 1..15.
- STARVE_MAX, 4, number of consecutive data grants allowed while a fetch is pending (used only with the optional feature); legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  fetch request; held with i_addr until i_ack
- i_addr  input  32  fetch word address
- i_rdata  output  32  fetch read data; valid while i_ack=1, held afterwards
- i_ack  output  1  one-cycle pulse when a fetch completes
- d_req  input  1  data request; held with all d_* fields until d_ack
- d_we  input  1  1=write, 0=read
- d_be  input  1  1=byte access, 0=word access
- d_addr  input  32  data address
- d_wdata  input  32  write data
- d_rdata  output  32  read data; valid while d_ack=1 after a read
- d_ack  output  1  one-cycle pulse when a data access completes
- mem_en  output  1  memory access active
- mem_we  output  1  memory write enable
- mem_be  output  1  memory byte-access flag
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en first rises
- busy  output  1  1 when state is not IDLE

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE, the latency counter is 0, and the starvation counter is 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If d_req=1, grant D. Otherwise, if i_req=1, grant I. Otherwise stay in IDLE.
  - On a grant, register owner, address, we, be and wdata (we=be=0 for I), load cnt=MEM_LAT-1, and go to ACCESS.
- ACCESS:
  - mem_en=1. mem_we, mem_be, mem_addr and mem_wdata are driven from the registered copies and stay stable for all MEM_LAT cycles.
  - If cnt!=0, decrement cnt. If cnt==0, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - The owner's ack=1 for exactly one cycle; mem_en=0; go to IDLE.
- Acks are registered outputs. i_ack and d_ack are never high in the same cycle.
- Latency:
  - A request seen in IDLE at cycle T gives ACCESS in cycles T+1..T+MEM_LAT and ack in cycle T+MEM_LAT+1.
  - Back-to-back accesses have a 1-cycle IDLE turnaround, so throughput is one access per MEM_LAT+2 cycles.
- Writes:
  - d_ack timing is the same as for reads.
  - d_rdata is not updated by a write and holds its last read value.
- Read data: i_rdata and d_rdata hold their value until the next read by the same owner completes.
- Request fields change while in ACCESS: ignored, because the access uses the latched copy.
- Request dropped before its ack: the access still completes and the ack is still pulsed; the requester ignores it.
- Reset mid-operation:
  - Immediately returns to IDLE and clears all outputs.
  - The in-flight access is abandoned with no ack. The write commit state of the memory is undefined.
- Simultaneous i_req and d_req in IDLE: D wins. I waits in IDLE with no lost request and is granted at the next IDLE in which d_req=0.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter counts consecutive D grants made while i_req=1. It clears on any I grant, and on any D grant made while i_req=0.
  - When the counter equals STARVE_MAX and i_req=1, the next IDLE grant goes to I even if d_req=1.
- Not defined: strict D-over-I priority, no counter logic, and fetch may starve indefinitely.

Test Plan:
- Fetch read, MEM_LAT=2:
  - Stimulus: i_req=1, i_addr=0x10 at cycle 0; memory returns 0xE3A00001.
  - Response: mem_en=1 in cycles 1–2 with mem_addr=0x10 and mem_we=0; i_ack=1 in cycle 3 only with i_rdata=0xE3A00001; busy=0 in cycle 4.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_be=1, d_addr=0x64, d_wdata=0x7.
  - Response: mem_we=1 and mem_be=1 for 2 cycles; d_ack in cycle 3; d_rdata unchanged from its prior value.
- Collision:
  - Stimulus: i_req and d_req both high at cycle 0, d read of 0x20 returns 0xAA.
  - Response: d_ack in cycle 3 with 0xAA; I granted in cycle 4; i_ack in cycle 7.
- Reset mid-access:
  - Stimulus: assert reset in cycle 2 of an ACCESS.
  - Response: mem_en, busy and both acks are 0 in the same cycle; no ack after release; a new request completes normally.
- Starvation, with ARB_STARVE_GUARD_EN, STARVE_MAX=4:
  - Stimulus: d_req held high continuously with i_req high.
  - Response: exactly 4 d_acks, then 1 i_ack, then D grants resume.
  - Without the macro: i_ack never occurs while d_req stays high.
- MEM_LAT=1 sweep:
  - Stimulus: alternating I/D reads.
  - Response: ack every 3 cycles; data matches a memory model on every ack.
